pit_data_rx: RTL and testbench

Pending Interest Table data responder for the NDN router. It stores pending interests (prefix, length, requesting face), answers the FIB's data-propagation handshake with either `start_send_to_pit` or `rejected`, and receives the `DATA_BYTES`-byte payload the FIB streams afterwards. It forwards that payload to every face that requested it, then retires the satisfied entries. It sits between the FIB data path and the outgoing face multiplexer.

---
 rtl/pit_data_rx.sv | 195 +++++++++++++++++++
 tb/tb_pit_data_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pit_data_rx.sv
// pit_data_rx: Pending Interest Table data responder.
// Stores pending interests, answers the FIB data handshake with an accept or
// reject pulse, then forwards the DATA_BYTES payload to every requesting face
// and retires the satisfied entries.
module pit_data_rx #(
  parameter int ENTRIES    = 8,
  parameter int DATA_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        interest_valid,
  input  logic [63:0] interest_prefix,
  input  logic [5:0]  interest_len,
  input  logic [1:0]  interest_face,
  output logic        interest_ready,
  output logic        interest_full,
  input  logic        fib_prefix_ready,
  input  logic [63:0] fib_prefix,
  input  logic [5:0]  fib_len,
  input  logic [7:0]  fib_data,
  output logic        start_send_to_pit,
  output logic        rejected,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic [3:0]  out_faces,
  output logic        out_first,
  output logic        out_last
);
  localparam int CW = $clog2(DATA_BYTES + 1);
  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    RESPOND = 2'd2,
    RECV    = 2'd3
  } state_t;

  state_t             state_r;
  logic [ENTRIES-1:0] valid_r;
  logic [63:0]        prefix_r [ENTRIES];
  logic [5:0]         len_r    [ENTRIES];
  logic [3:0]         mask_r   [ENTRIES];
  logic [63:0]        key_prefix_r;
  logic [5:0]         key_len_r;
  logic [ENTRIES-1:0] hit_r;
  logic [3:0]         hit_faces_r;
  logic [CW-1:0]      cnt_r;

  logic [ENTRIES-1:0] ins_hit_s;
  logic [ENTRIES-1:0] look_hit_s;
  logic [3:0]         look_faces_s;
  logic [IW-1:0]      ins_hit_idx_s;
  logic [IW-1:0]      ins_free_idx_s;
  logic               ins_any_hit_s;
  logic               ins_any_free_s;
  logic               ins_fire_s;
  logic               fib_fire_s;
  logic               sample_s;
  logic               retire_s;
  logic [3:0]         face_bit_s;

  // interest_ready is a registered copy of "in IDLE", so it gates both handshakes
  assign ins_fire_s     = interest_ready && (state_r == IDLE) && interest_valid;
  assign fib_fire_s     = interest_ready && (state_r == IDLE) && fib_prefix_ready;
  // the first RECV cycle carries the accept pulse; capture starts one cycle later
  assign sample_s       = (state_r == RECV) && !start_send_to_pit;
  assign retire_s       = sample_s && (cnt_r == CW'(DATA_BYTES - 1));
  assign face_bit_s     = 4'b0001 << interest_face;
  assign ins_any_hit_s  = |ins_hit_s;
  assign ins_any_free_s = ~(&valid_r);

  // Associative compare: insert match, lowest free slot, and lookup match/faces
  always_comb begin
    ins_hit_s      = '0;
    look_hit_s     = '0;
    look_faces_s   = 4'b0000;
    ins_hit_idx_s  = '0;
    ins_free_idx_s = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_r[i] && (len_r[i] == interest_len) && (prefix_r[i] == interest_prefix)) begin
        ins_hit_s[i]  = 1'b1;
        ins_hit_idx_s = IW'(i);
      end else begin
        ins_hit_s[i]  = 1'b0;
      end
      if (!valid_r[i]) begin
        ins_free_idx_s = IW'(i);
      end else begin
        ins_free_idx_s = ins_free_idx_s;
      end
      if (valid_r[i] && (len_r[i] == key_len_r) && (prefix_r[i] == key_prefix_r)) begin
        look_hit_s[i] = 1'b1;
        look_faces_s  = look_faces_s | mask_r[i];
      end else begin
        look_hit_s[i] = 1'b0;
      end
    end
  end

  // Table storage: insert/aggregate in IDLE, retire matched entries at packet end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        prefix_r[i] <= 64'd0;
        len_r[i]    <= 6'd0;
        mask_r[i]   <= 4'd0;
      end
    end else if (ins_fire_s) begin
      if (ins_any_hit_s) begin
        mask_r[ins_hit_idx_s] <= mask_r[ins_hit_idx_s] | face_bit_s;
      end else if (ins_any_free_s) begin
        valid_r[ins_free_idx_s]  <= 1'b1;
        prefix_r[ins_free_idx_s] <= interest_prefix;
        len_r[ins_free_idx_s]    <= interest_len;
        mask_r[ins_free_idx_s]   <= face_bit_s;
      end
    end else if (retire_s) begin
      valid_r <= valid_r & ~hit_r;
    end
  end

  // Handshake FSM with registered pulses and payload output stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= IDLE;
      key_prefix_r      <= 64'd0;
      key_len_r         <= 6'd0;
      hit_r             <= '0;
      hit_faces_r       <= 4'd0;
      cnt_r             <= '0;
      interest_ready    <= 1'b0;
      interest_full     <= 1'b0;
      start_send_to_pit <= 1'b0;
      rejected          <= 1'b0;
      out_valid         <= 1'b0;
      out_data          <= 8'd0;
      out_faces         <= 4'd0;
      out_first         <= 1'b0;
      out_last          <= 1'b0;
    end else begin
      start_send_to_pit <= 1'b0;
      rejected          <= 1'b0;
      interest_full     <= ins_fire_s && !ins_any_hit_s && !ins_any_free_s;
      out_valid         <= sample_s;
      out_data          <= sample_s ? fib_data : 8'd0;
      out_faces         <= sample_s ? hit_faces_r : 4'd0;
      out_first         <= sample_s && (cnt_r == '0);
      out_last          <= retire_s;
      case (state_r)
        IDLE: begin
          if (fib_fire_s) begin
            key_prefix_r   <= fib_prefix;
            key_len_r      <= fib_len;
            interest_ready <= 1'b0;
            state_r        <= LOOKUP;
          end else begin
            interest_ready <= 1'b1;
          end
        end
        LOOKUP: begin
          hit_r       <= look_hit_s;
          hit_faces_r <= look_faces_s;
          state_r     <= RESPOND;
        end
        RESPOND: begin
          if (|hit_r) begin
            start_send_to_pit <= 1'b1;
            cnt_r             <= '0;
            state_r           <= RECV;
          end else begin
            rejected       <= 1'b1;
            interest_ready <= 1'b1;
            state_r        <= IDLE;
          end
        end
        RECV: begin
          if (sample_s) begin
            cnt_r <= cnt_r + CW'(1);
          end
          if (retire_s) begin
            interest_ready <= 1'b1;
            state_r        <= IDLE;
          end
        end
        default: begin
          interest_ready <= 1'b0;
          state_r        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pit_data_rx.sv
// Scoreboard bench for pit_data_rx: stimulus pushes expected events with their
// cycle of appearance, a negedge monitor pops and compares each DUT output event.
module tb_pit_data_rx;
  localparam int ENTRIES    = 8;
  localparam int DATA_BYTES = 1024;
  localparam int EV_FULL  = 0;
  localparam int EV_START = 1;
  localparam int EV_REJ   = 2;
  localparam int EV_BYTE  = 3;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] data;
    logic [3:0] faces;
    logic       first;
    logic       last;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cycle  = 0;

  logic        clk;
  logic        rst;
  logic        interest_valid;
  logic [63:0] interest_prefix;
  logic [5:0]  interest_len;
  logic [1:0]  interest_face;
  logic        interest_ready;
  logic        interest_full;
  logic        fib_prefix_ready;
  logic [63:0] fib_prefix;
  logic [5:0]  fib_len;
  logic [7:0]  fib_data;
  logic        start_send_to_pit;
  logic        rejected;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [3:0]  out_faces;
  logic        out_first;
  logic        out_last;

  pit_data_rx #(.ENTRIES(ENTRIES), .DATA_BYTES(DATA_BYTES)) dut (
    .clk(clk), .rst(rst),
    .interest_valid(interest_valid), .interest_prefix(interest_prefix),
    .interest_len(interest_len), .interest_face(interest_face),
    .interest_ready(interest_ready), .interest_full(interest_full),
    .fib_prefix_ready(fib_prefix_ready), .fib_prefix(fib_prefix),
    .fib_len(fib_len), .fib_data(fib_data),
    .start_send_to_pit(start_send_to_pit), .rejected(rejected),
    .out_valid(out_valid), .out_data(out_data), .out_faces(out_faces),
    .out_first(out_first), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle n is the period following the n-th rising edge
  always @(posedge clk) cycle <= cycle + 1;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input int kind, input int cyc, input logic [7:0] d,
                      input logic [3:0] f, input logic fi, input logic la);
    ev_t e;
    e.kind = kind; e.cyc = cyc; e.data = d; e.faces = f; e.first = fi; e.last = la;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [7:0] d, input logic [3:0] f,
                         input logic fi, input logic la);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d cyc=%0d data=%02h faces=%b, expected none",
               kind, cycle, d, f);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cycle || e.data !== d || e.faces !== f ||
          e.first !== fi || e.last !== la) begin
        errors++;
        $display("FAIL event: got kind=%0d cyc=%0d data=%02h faces=%b first=%b last=%b, expected kind=%0d cyc=%0d data=%02h faces=%b first=%b last=%b",
                 kind, cycle, d, f, fi, la, e.kind, e.cyc, e.data, e.faces, e.first, e.last);
      end
    end
  endtask

  // Monitor: every output event must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (interest_full)     observe(EV_FULL, 8'd0, 4'd0, 1'b0, 1'b0);
      if (start_send_to_pit) observe(EV_START, 8'd0, 4'd0, 1'b0, 1'b0);
      if (rejected)          observe(EV_REJ, 8'd0, 4'd0, 1'b0, 1'b0);
      if (out_valid) begin
        observe(EV_BYTE, out_data, out_faces, out_first, out_last);
      end else if (out_faces != 4'd0 || out_first || out_last) begin
        checks++;
        errors++;
        $display("FAIL idle_outputs: got faces=%b first=%b last=%b, expected all 0",
                 out_faces, out_first, out_last);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("outputs_in_reset",
          {interest_ready, interest_full, start_send_to_pit, rejected, out_valid,
           out_data, out_faces, out_first, out_last}, 64'd0);
    step();
    step();
    rst = 1'b0;
    check("ready_low_at_release", interest_ready, 1'b0);
    step();
    check("ready_after_reset", interest_ready, 1'b1);
  endtask

  task automatic insert(input logic [63:0] p, input logic [5:0] l,
                        input logic [1:0] face, input bit full);
    check("ready_before_insert", interest_ready, 1'b1);
    interest_valid  = 1'b1;
    interest_prefix = p;
    interest_len    = l;
    interest_face   = face;
    if (full) push(EV_FULL, cycle + 1, 8'd0, 4'd0, 1'b0, 1'b0);
    step();
    interest_valid = 1'b0;
  endtask

  // Offer a prefix; on accept, stream payload bytes 0,1,2,... and expect nbytes outputs
  task automatic offer(input logic [63:0] p, input logic [5:0] l, input bit acc,
                       input logic [3:0] f, input int nbytes);
    int t;
    fib_prefix       = p;
    fib_len          = l;
    fib_prefix_ready = 1'b1;
    t = cycle + 1;
    if (acc) begin
      push(EV_START, t + 2, 8'd0, 4'd0, 1'b0, 1'b0);
      for (int j = 0; j < nbytes; j++) begin
        push(EV_BYTE, t + 4 + j, 8'(j), f, (j == 0), (j == DATA_BYTES - 1));
      end
    end else begin
      push(EV_REJ, t + 2, 8'd0, 4'd0, 1'b0, 1'b0);
    end
    step();
    fib_prefix_ready = 1'b0;
    interest_valid   = 1'b0;
    if (acc) begin
      while (cycle < t + 4 + nbytes) begin
        fib_data = (cycle >= t + 3) ? 8'(cycle - t - 3) : 8'h00;
        step();
      end
      fib_data = 8'h00;
    end else begin
      repeat (3) step();
    end
  endtask

  initial begin
    rst              = 1'b1;
    interest_valid   = 1'b0;
    interest_prefix  = 64'd0;
    interest_len     = 6'd0;
    interest_face    = 2'd0;
    fib_prefix_ready = 1'b0;
    fib_prefix       = 64'd0;
    fib_len          = 6'd0;
    fib_data         = 8'd0;
    step();
    do_reset();

    // Reject on an empty table
    offer(64'hA5A5_0000_0000_0000, 6'd16, 1'b0, 4'd0, 0);

    // Aggregated accept from faces 0 and 2, then the entry is gone
    insert(64'h1234_5678_9ABC_DEF0, 6'd20, 2'd0, 1'b0);
    insert(64'h1234_5678_9ABC_DEF0, 6'd20, 2'd2, 1'b0);
    offer(64'h1234_5678_9ABC_DEF0, 6'd20, 1'b1, 4'b0101, DATA_BYTES);
    offer(64'h1234_5678_9ABC_DEF0, 6'd20, 1'b0, 4'd0, 0);

    // Length mismatch rejects but leaves the entry valid
    insert(64'h0BAD_CAFE_0000_1111, 6'd12, 2'd3, 1'b0);
    offer(64'h0BAD_CAFE_0000_1111, 6'd13, 1'b0, 4'd0, 0);
    offer(64'h0BAD_CAFE_0000_1111, 6'd12, 1'b1, 4'b1000, DATA_BYTES);

    // Table full: ninth distinct prefix dropped
    for (int i = 0; i < ENTRIES; i++) begin
      insert(64'hF000_0000_0000_0000 + 64'(i), 6'd40, 2'(i % 4), 1'b0);
    end
    insert(64'hF000_0000_0000_0000 + 64'(ENTRIES), 6'd40, 2'd1, 1'b1);
    offer(64'hF000_0000_0000_0000 + 64'(ENTRIES), 6'd40, 1'b0, 4'd0, 0);
    for (int i = 0; i < ENTRIES; i++) begin
      offer(64'hF000_0000_0000_0000 + 64'(i), 6'd40, 1'b1, 4'(1 << (i % 4)), DATA_BYTES);
    end

    // Simultaneous insert and offer in the same IDLE cycle
    check("ready_before_simul", interest_ready, 1'b1);
    interest_valid  = 1'b1;
    interest_prefix = 64'h5151_7777_0000_ABCD;
    interest_len    = 6'd33;
    interest_face   = 2'd1;
    offer(64'h5151_7777_0000_ABCD, 6'd33, 1'b1, 4'b0010, DATA_BYTES);

    // Reset after 100 payload bytes
    insert(64'hDEAD_BEEF_0000_0042, 6'd50, 2'd2, 1'b0);
    offer(64'hDEAD_BEEF_0000_0042, 6'd50, 1'b1, 4'b0100, 100);
    check("queue_drained_before_reset", 64'(exp_q.size()), 64'd0);
    do_reset();
    repeat (3) step();
    offer(64'hDEAD_BEEF_0000_0042, 6'd50, 1'b0, 4'd0, 0);

    repeat (4) step();
    check("queue_empty_at_end", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
